// File: rtl/q100_mem_pkg.sv
// q100 MEM stage shared definitions: FSM states, funct3 and opcode encodings,
// datapath widths and a misalignment helper.
package q100_mem_pkg;

    localparam int unsigned LEN_OPCODE   = 7;
    localparam int unsigned LEN_REG_VAL  = 32;
    localparam int unsigned LEN_RD       = 5;
    localparam int unsigned LEN_CSR_ADDR = 12;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp
    } mem_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // Halfword accesses need addr[0]=0, word accesses need addr[1:0]=0.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
        logic bad;
        bad = 1'b0;
        if (funct3[1:0] == 2'b01) bad = addr[0];
        if (funct3[1:0] == 2'b10) bad = (addr != 2'b00);
        return bad;
    endfunction

endpackage

// File: rtl/q100_mem_align.sv
// q100 MEM lane steering: store byte enables / replicated write data, and
// load lane extraction with sign or zero extension. Purely combinational.
// Low address bits that do not select a lane for the access width are ignored,
// so a misaligned access is implicitly aligned down.
module q100_mem_align
    import q100_mem_pkg::*;
(
    input  logic [2:0]             funct3,
    input  logic [1:0]             addr,
    input  logic [LEN_REG_VAL-1:0] st_data,
    input  logic [LEN_REG_VAL-1:0] rdata,
    output logic [3:0]             be,
    output logic [LEN_REG_VAL-1:0] wdata,
    output logic [LEN_REG_VAL-1:0] ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store side: byte enables and lane-replicated data.
    always_comb begin
        be    = 4'b0000;
        wdata = st_data;
        case (funct3)
            F3_SB: begin
                be    = 4'b0001 << addr;
                wdata = {4{st_data[7:0]}};
            end
            F3_SH: begin
                be    = 4'b0011 << {addr[1], 1'b0};
                wdata = {2{st_data[15:0]}};
            end
            F3_SW: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Load side: pick the addressed lane and extend it.
    always_comb begin
        byte_sel = rdata[7:0];
        case (addr)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:  ld_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:  ld_data = {{16{half_sel[15]}}, half_sel};
            F3_LBU: ld_data = {24'd0, byte_sel};
            F3_LHU: ld_data = {16'd0, half_sel};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/q100_mem.sv
// q100 MEM pipeline stage: accepts one EX result per handshake, performs RV32I
// loads/stores on the DTCM (req/gnt/rvalid) and presents registered,
// retire-qualified controls to WB.
// Optional build macro Q100_MEM_MISALIGN_EN: adds misalign_o and retires
// misaligned halfword/word accesses without touching the DTCM.
module q100_mem
    import q100_mem_pkg::*;
#(
    parameter int unsigned DTCM_AW = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ex_vld_i,
    output logic                    ex_rdy_o,
    input  logic [LEN_OPCODE-1:0]   opcode_i,
    input  logic [2:0]              funct3_i,
    input  logic [LEN_REG_VAL-1:0]  alu_result_i,
    input  logic [LEN_REG_VAL-1:0]  rs2_value_i,
    input  logic [LEN_RD-1:0]       rd_i,
    input  logic                    WB_i,
    input  logic                    CSR_i,
    input  logic [LEN_REG_VAL-1:0]  csr_value_i,
    input  logic [LEN_CSR_ADDR-1:0] csr_addr_i,
    output logic                    dtcm_req_o,
    output logic                    dtcm_we_o,
    output logic [DTCM_AW-1:0]      dtcm_addr_o,
    output logic [LEN_REG_VAL-1:0]  dtcm_wdata_o,
    output logic [3:0]              dtcm_be_o,
    input  logic                    dtcm_gnt_i,
    input  logic                    dtcm_rvalid_i,
    input  logic [LEN_REG_VAL-1:0]  dtcm_rdata_i,
    output logic                    WB_o,
    output logic                    CSR_o,
    output logic [LEN_REG_VAL-1:0]  csr_value_o,
    output logic [LEN_CSR_ADDR-1:0] csr_addr_o,
    output logic [LEN_OPCODE-1:0]   opcode_o,
    output logic [LEN_REG_VAL-1:0]  alu_result_o,
    output logic [LEN_RD-1:0]       rd_o,
    output logic [LEN_REG_VAL-1:0]  dtcm_rd_data_o,
`ifdef Q100_MEM_MISALIGN_EN
    output logic                    misalign_o,
`endif
    output logic                    wb_sel_o
);

    mem_state_e state_q, state_d;

    logic [LEN_OPCODE-1:0]   opcode_q;
    logic [2:0]              funct3_q;
    logic [LEN_REG_VAL-1:0]  alu_q;
    logic [LEN_REG_VAL-1:0]  rs2_q;
    logic [LEN_RD-1:0]       rd_q;
    logic                    wb_q;
    logic                    csr_q;
    logic [LEN_REG_VAL-1:0]  csr_value_q;
    logic [LEN_CSR_ADDR-1:0] csr_addr_q;
    // Captured op retires from IDLE on the next cycle without a DTCM access.
    logic                    fast_q;
    logic                    misal_q;

    logic                    accept;
    logic                    is_mem_in;
    logic                    misal_in;
    logic                    store_q;
    logic                    load_q;
    logic                    retire;
    logic [3:0]              st_be;
    logic [LEN_REG_VAL-1:0]  st_wdata;
    logic [LEN_REG_VAL-1:0]  ld_ext;

    assign ex_rdy_o  = (state_q == StIdle);
    assign accept    = ex_vld_i & ex_rdy_o;
    assign is_mem_in = (opcode_i == OP_LOAD) || (opcode_i == OP_STORE);
    assign store_q   = (opcode_q == OP_STORE);
    assign load_q    = (opcode_q == OP_LOAD);

`ifdef Q100_MEM_MISALIGN_EN
    assign misal_in = is_mem_in & is_misaligned(funct3_i, alu_result_i[1:0]);

    // Misalignment flag travels with the captured instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            misal_q <= 1'b0;
        end else if (accept) begin
            misal_q <= misal_in;
        end
    end
`else
    assign misal_in = 1'b0;
    assign misal_q  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and retire qualification.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            StIdle: begin
                retire = fast_q;
                if (accept && is_mem_in && !misal_in) state_d = StReq;
            end
            StReq: begin
                if (dtcm_gnt_i) begin
                    if (store_q) begin
                        retire  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                if (dtcm_rvalid_i) begin
                    retire  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Capture the whole EX bundle on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            opcode_q    <= '0;
            funct3_q    <= '0;
            alu_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            wb_q        <= 1'b0;
            csr_q       <= 1'b0;
            csr_value_q <= '0;
            csr_addr_q  <= '0;
            fast_q      <= 1'b0;
        end else begin
            fast_q <= accept && (!is_mem_in || misal_in);
            if (accept) begin
                opcode_q    <= opcode_i;
                funct3_q    <= funct3_i;
                alu_q       <= alu_result_i;
                rs2_q       <= rs2_value_i;
                rd_q        <= rd_i;
                wb_q        <= WB_i;
                csr_q       <= CSR_i;
                csr_value_q <= csr_value_i;
                csr_addr_q  <= csr_addr_i;
            end
        end
    end

    q100_mem_align u_align (
        .funct3  (funct3_q),
        .addr    (alu_q[1:0]),
        .st_data (rs2_q),
        .rdata   (dtcm_rdata_i),
        .be      (st_be),
        .wdata   (st_wdata),
        .ld_data (ld_ext)
    );

    // DTCM request is driven purely from captured state, so it is stable until grant.
    assign dtcm_req_o   = (state_q == StReq);
    assign dtcm_we_o    = dtcm_req_o & store_q;
    assign dtcm_addr_o  = {alu_q[DTCM_AW-1:2], 2'b00};
    assign dtcm_wdata_o = st_wdata;
    assign dtcm_be_o    = !dtcm_req_o ? 4'b0000 : (store_q ? st_be : 4'b1111);

    // WB-facing registers: write strobes pulse for one cycle, the rest hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            WB_o           <= 1'b0;
            CSR_o          <= 1'b0;
            csr_value_o    <= '0;
            csr_addr_o     <= '0;
            opcode_o       <= '0;
            alu_result_o   <= '0;
            rd_o           <= '0;
            dtcm_rd_data_o <= '0;
            wb_sel_o       <= 1'b0;
        end else begin
            WB_o  <= 1'b0;
            CSR_o <= 1'b0;
            if (retire) begin
                WB_o         <= wb_q & ~store_q & ~misal_q;
                CSR_o        <= csr_q;
                csr_value_o  <= csr_value_q;
                csr_addr_o   <= csr_addr_q;
                opcode_o     <= opcode_q;
                alu_result_o <= alu_q;
                rd_o         <= rd_q;
                wb_sel_o     <= load_q;
                if (state_q == StResp) dtcm_rd_data_o <= ld_ext;
            end
        end
    end

`ifdef Q100_MEM_MISALIGN_EN
    // Misalignment strobe accompanies the retire of the offending access.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= retire & misal_q;
        end
    end
`endif

endmodule
